// File: rtl/ej32_div.sv
// Sequential signed divider for the eJ32 AU (idiv/irem): radix-2 restoring on
// magnitudes, one quotient bit per cycle, Java truncating quotient and remainder signs.
module ej32_div #(
    parameter int DSZ = 32,
    parameter int CW  = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [DSZ-1:0] x,
    input  logic [DSZ-1:0] y,
    output logic           busy,
    output logic           done,
    output logic           z,
    output logic [DSZ-1:0] q,
    output logic [DSZ-1:0] r
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_ZERO
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [DSZ-1:0] r_dvd;     // dividend magnitude, becomes the quotient magnitude
    logic [DSZ-1:0] r_dsr;
    logic [DSZ-1:0] r_rem;
    logic [DSZ-1:0] r_x;
    logic [DSZ-1:0] r_y;
    logic           r_sq;
    logic           r_sr;
    logic           r_busy;
    logic           r_done;
    logic           r_z;
    logic [DSZ-1:0] r_q;
    logic [DSZ-1:0] r_r;

    logic [DSZ-1:0] w_ax;
    logic [DSZ-1:0] w_ay;
    logic [DSZ:0]   w_shift;
    logic [DSZ:0]   w_trial;
    logic           w_qbit;
    logic [DSZ-1:0] w_q_fix;
    logic [DSZ-1:0] w_r_fix;

    // |MIN| wraps to MIN, which is exactly 2^(DSZ-1) read as unsigned.
    assign w_ax    = x[DSZ-1] ? -x : x;
    assign w_ay    = y[DSZ-1] ? -y : y;
    // The shifted partial remainder needs one extra bit before the trial subtract.
    assign w_shift = {r_rem, r_dvd[DSZ-1]};
    assign w_trial = w_shift - {1'b0, r_dsr};
    assign w_qbit  = ~w_trial[DSZ];
    assign w_q_fix = r_sq ? -r_dvd : r_dvd;
    assign w_r_fix = r_sr ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_rem   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_sq    <= 1'b0;
            r_sr    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_z     <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_dvd   <= w_ax;
                            r_dsr   <= w_ay;
                            r_x     <= x;
                            r_y     <= y;
                            r_sq    <= x[DSZ-1] ^ y[DSZ-1];
                            r_sr    <= x[DSZ-1];
                            r_rem   <= '0;
                            r_cnt   <= CW'(DSZ - 1);
                            r_busy  <= 1'b1;
                            r_state <= (y == '0) ? S_ZERO : S_ITER;
                        end
                    end
                    S_ITER: begin
                        r_rem <= w_qbit ? w_trial[DSZ-1:0] : w_shift[DSZ-1:0];
                        r_dvd <= {r_dvd[DSZ-2:0], w_qbit};
                        if (r_cnt == '0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_FIX: begin
                        r_q     <= w_q_fix;
                        r_r     <= w_r_fix;
                        r_z     <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    S_ZERO: begin
                        r_q     <= '0;
                        r_r     <= r_x;
                        r_z     <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    logic [DSZ-1:0] w_chk_sum;
    assign w_chk_sum = w_q_fix * r_y + w_r_fix;

    always_ff @(posedge clk) begin
        if (!rst && !abort && r_state == S_FIX) begin
            assert (w_chk_sum == r_x && r_rem < r_dsr);
        end
    end
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign z    = r_z;
    assign q    = r_q;
    assign r    = r_r;

endmodule

// File: tb/tb_ej32_div.sv
// Scoreboard bench for ej32_div: stimulus pushes expected results, a monitor
// pops and compares them on every done pulse, including the done cycle number.
module tb_ej32_div;

    localparam int DSZ = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [DSZ-1:0]  x;
    logic [DSZ-1:0]  y;
    logic            busy;
    logic            done;
    logic            z;
    logic [DSZ-1:0]  q;
    logic [DSZ-1:0]  r;

    ej32_div #(.DSZ(DSZ), .CW(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .q     (q),
        .r     (r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cycle=%0d q=0x%08h r=0x%08h", cyc, q, r);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("op x=0x%08h y=0x%08h -> q=0x%08h r=0x%08h z=%0d cycle=%0d",
                         e.x, e.y, q, r, z, cyc);
                chk("q", q, e.q);
                chk("r", r, e.r);
                chk("z", {31'd0, z}, {31'd0, e.z});
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Drive at a negedge; accept edge is the next posedge.
    task automatic issue(input logic [31:0] ix, input logic [31:0] iy, input logic [31:0] eq,
                         input logic [31:0] er, input logic ez, input bit push);
        exp_t e;
        start = 1'b1;
        x = ix;
        y = iy;
        if (push) begin
            e.x = ix; e.y = iy; e.q = eq; e.r = er; e.z = ez;
            e.cyc = cyc + 1 + ((iy == 0) ? 1 : DSZ + 1);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        if (iy != 0) chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done within 60 cycles");
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[20] = '{
        '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0},
        '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0},
        '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0},
        '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0},
        '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0},
        '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0},
        '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0},
        '{32'd5,        32'h80000000, 32'd0,        32'd5,        1'b0},
        '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0},
        '{32'h80000000, 32'd3,        32'hD5555556, 32'hFFFFFFFE, 1'b0},
        '{32'h7FFFFFFF, 32'd2,        32'h3FFFFFFF, 32'd1,        1'b0},
        '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 32'd0,        1'b0},
        '{32'd3,        32'd5,        32'd0,        32'd3,        1'b0},
        '{32'hFFFFFFFD, 32'd5,        32'd0,        32'hFFFFFFFD, 1'b0},
        '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0},
        '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0},
        '{32'd12345,    32'hFFFFFF85, 32'hFFFFFF9C, 32'd45,       1'b0},
        '{32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b1},
        '{32'd5,        32'd0,        32'd0,        32'd5,        1'b1},
        '{32'd9,        32'd3,        32'd3,        32'd0,        1'b0}
    };

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_z", {31'd0, z}, 32'd0);
        chk("rst_q", q, 32'd0);
        chk("rst_r", r, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Each new op starts in the done cycle of the previous one.
        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, vecs[i].z, 1'b1);
            wait_done();
        end

        // Abort mid-operation; a stray start while busy must be ignored.
        issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; x = 32'd1; y = 32'd1;
        @(negedge clk);
        start = 1'b0; x = '0; y = '0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_q_kept", q, 32'd3);
        chk("abort_r_kept", r, 32'd0);
        chk("abort_z_kept", {31'd0, z}, 32'd0);

        // abort with start in IDLE: start is not accepted.
        start = 1'b1; abort = 1'b1; x = 32'd100; y = 32'd7;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle_busy", {31'd0, busy}, 32'd0);

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        // Reset mid-operation clears outputs and produces no done.
        issue(32'd50, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_q", q, 32'd0);
        chk("midrst_r", r, 32'd0);
        repeat (40) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ej32_div.md
Name: ej32_div

Overview:
- Sequential signed integer divider serving the eJ32 arithmetic unit for idiv and irem.
- Takes NOS (dividend) and TOS (divisor) from the AU and returns quotient and remainder with Java semantics.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- The AU stalls its FSM on busy and consumes q/r on done.

Parameters:
- DSZ, 32: operand and result width in bits; must be >= 4.
- CW, 6: iteration counter width; must satisfy 2^CW > DSZ.

Ports:
- clk  in  1  system clock, shared with the control bus clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- abort  in  1  cancel the current operation and return to IDLE
- x  in  DSZ  dividend (NOS), signed, captured on accepted start
- y  in  DSZ  divisor (TOS), signed, captured on accepted start
- busy  out  1  operation in progress (not IDLE)
- done  out  1  one-cycle pulse; q, r, z valid from this cycle on
- z  out  1  divide-by-zero flag for the last completed operation
- q  out  DSZ  quotient, truncated toward zero
- r  out  DSZ  remainder; carries the sign of the dividend

Behaviour:
- Reset and state:
  - All state updates on posedge clk.
  - rst=1 wins over every other input.
  - On reset: state=IDLE; busy, done, z = 0; q, r = 0; counter = 0.
- States:
  - IDLE -> ITER when start=1 and y!=0.
  - IDLE -> ZERO when start=1 and y==0.
  - ITER stays for DSZ cycles, counting down from DSZ-1 to 0.
  - ITER -> FIX when counter==0.
  - FIX -> IDLE.
  - ZERO -> IDLE.
- Accept edge (start in IDLE):
  - Latch |x| into the working dividend and |y| into the divisor.
  - Latch sq = x[DSZ-1]^y[DSZ-1] and sr = x[DSZ-1].
  - Clear the partial remainder (DSZ+1 bits) and set counter = DSZ-1.
- ITER step:
  - Shift {rem, dvd} left by 1.
  - Trial-subtract the divisor; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
- FIX edge:
  - q <= sq ? -quot : quot; r <= sr ? -rem : rem.
  - z <= 0; done <= 1.
- ZERO edge:
  - q <= 0; r <= x latched at accept; z <= 1; done <= 1.
- Timing:
  - busy is 1 in every non-IDLE state, registered, so it rises on the accept edge.
  - Normal latency: done is high in the cycle after FIX, i.e. DSZ+1 cycles after the accept edge.
  - Divide-by-zero latency: done is high 1 cycle after the accept edge.
  - done falls the following cycle. busy is already 0 in the done cycle.
- Result persistence: q, r and z hold their values until the next FIX or ZERO edge, or reset.
- Arithmetic rules:
  - Absolute values and negations are DSZ-bit two's complement.
  - |MIN| = MIN is treated as unsigned 2^(DSZ-1), which is correct in DSZ-bit unsigned arithmetic.
  - MIN / -1 yields q=MIN, r=0 (Java wrap, no trap).
  - |x| < |y| yields q=0, r=x.
- start while busy: ignored; the operands are not recaptured.
- start in the done cycle: accepted, since state is IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; busy falls next edge.
  - No done pulse; q, r and z are unchanged.
- abort=1 in IDLE:
  - Has no effect.
  - abort together with start in IDLE: abort wins and start is not accepted.
- rst mid-operation: returns to IDLE with all outputs cleared; no done.
- Simulation-only assertion at the FIX edge: q*y + r == x, and |r| < |y|.

Test Plan:
- x=7, y=2, start one cycle -> busy for 33 cycles; done 33 cycles after accept with q=3, r=1, z=0.
- x=-7 (0xFFFFFFF9), y=2 -> q=-3 (0xFFFFFFFD), r=-1 (0xFFFFFFFF). Then x=7, y=-2 -> q=-3, r=1.
- x=0x80000000, y=0xFFFFFFFF -> q=0x80000000, r=0. Then x=0x80000000, y=1 -> q=0x80000000, r=0.
- x=5, y=0 -> done one cycle after accept with z=1, q=0, r=5. The next op x=9, y=3 clears z: q=3, r=0.
- Start x=100, y=7; pulse start with x=1, y=1 at cycle 5; pulse abort at cycle 10 -> no done, busy low at cycle 11, q and r retain their prior values. Restart 100/7 -> q=14, r=2.
- Random signed pairs with y!=0, including back-to-back start in the done cycle -> q and r match Java / and % for every pair; no lost or duplicated done pulses.
